// File: rtl/axil_read_regbank.sv
// axil_read_regbank: AXI4-Lite bank of NUM_WORDS read-only status words with per-word read strobes.
// Reading even word 2k captures word 2k+1 into a shadow so the pair reads coherently.
module axil_read_regbank #(
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = 16,
    parameter int NUM_WORDS      = 8,
    parameter int PAIR_SNAPSHOT  = 1,
    parameter int WR_ERR         = 0
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic [AXI_ADDR_WIDTH-1:0]     s_axi_awaddr,
    input  logic [2:0]                    s_axi_awprot,
    input  logic                          s_axi_awvalid,
    output logic                          s_axi_awready,
    input  logic [AXI_DATA_WIDTH-1:0]     s_axi_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0]   s_axi_wstrb,
    input  logic                          s_axi_wvalid,
    output logic                          s_axi_wready,
    output logic [1:0]                    s_axi_bresp,
    output logic                          s_axi_bvalid,
    input  logic                          s_axi_bready,
    input  logic [AXI_ADDR_WIDTH-1:0]     s_axi_araddr,
    input  logic [2:0]                    s_axi_arprot,
    input  logic                          s_axi_arvalid,
    output logic                          s_axi_arready,
    output logic [AXI_DATA_WIDTH-1:0]     s_axi_rdata,
    output logic [1:0]                    s_axi_rresp,
    output logic                          s_axi_rvalid,
    input  logic                          s_axi_rready,
    input  logic [NUM_WORDS*32-1:0]       readdata,
    output logic [NUM_WORDS-1:0]          rd_strobe
);
    localparam int IDXW  = $clog2(NUM_WORDS);
    localparam int NPAIR = NUM_WORDS / 2;
    localparam int PW    = (IDXW > 1) ? IDXW - 1 : 1;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    typedef enum logic {R_IDLE, R_DATA} rstate_t;
    typedef enum logic {W_IDLE, W_RESP} wstate_t;

    rstate_t                   rstate_q;
    wstate_t                   wstate_q;
    logic                      arready_q, rvalid_q, rok_q;
    logic [AXI_DATA_WIDTH-1:0] rdata_q;
    logic [1:0]                rresp_q, bresp_q;
    logic [IDXW-1:0]           ridx_q;
    logic [NUM_WORDS-1:0]      rd_strobe_q;
    logic [31:0]               shadow_q [NPAIR];
    logic                      awready_q, wready_q, bvalid_q, aw_got_q, w_got_q;
    logic [IDXW-1:0]           idx_d;
    logic [PW-1:0]             pidx_d;
    logic                      in_range_d, aw_got_d, w_got_d;
    logic [31:0]               rdata_d, pair_d;
    logic                      unused_ok;

    assign idx_d      = s_axi_araddr[IDXW+1:2];
    assign pidx_d     = PW'(idx_d >> 1);
    assign in_range_d = (s_axi_araddr >> (IDXW + 2)) == '0;
    assign unused_ok  = ^{s_axi_awaddr, s_axi_awprot, s_axi_wdata, s_axi_wstrb, s_axi_arprot, s_axi_araddr[1:0]};

    // Odd words come from the shadow captured by the preceding even read
    always_comb begin
        rdata_d  = (PAIR_SNAPSHOT != 0 && idx_d[0]) ? shadow_q[pidx_d] : readdata[32*int'(idx_d) +: 32];
        pair_d   = readdata[32*int'(idx_d | IDXW'(1)) +: 32];
        aw_got_d = aw_got_q | (s_axi_awvalid & awready_q);
        w_got_d  = w_got_q | (s_axi_wvalid & wready_q);
    end

    always_ff @(posedge aclk) begin
        rd_strobe_q <= '0;
        if (!aresetn) begin
            rstate_q  <= R_IDLE;
            arready_q <= 1'b1;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= OKAY;
            ridx_q    <= '0;
            rok_q     <= 1'b0;
            for (int i = 0; i < NPAIR; i++) shadow_q[i] <= '0;
        end else if (rstate_q == R_IDLE) begin
            if (s_axi_arvalid && arready_q) begin
                rstate_q  <= R_DATA;
                arready_q <= 1'b0;
                rvalid_q  <= 1'b1;
                rdata_q   <= in_range_d ? AXI_DATA_WIDTH'(rdata_d) : '0;
                rresp_q   <= in_range_d ? OKAY : SLVERR;
                ridx_q    <= idx_d;
                rok_q     <= in_range_d;
                if (PAIR_SNAPSHOT != 0 && in_range_d && !idx_d[0]) shadow_q[pidx_d] <= pair_d;
            end
        end else if (s_axi_rready) begin
            rstate_q    <= R_IDLE;
            arready_q   <= 1'b1;
            rvalid_q    <= 1'b0;
            rdata_q     <= '0;
            rresp_q     <= OKAY;
            rd_strobe_q <= rok_q ? NUM_WORDS'(1) << ridx_q : '0;
        end
    end

    // Write data is accepted and dropped; only the response is generated
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            wstate_q  <= W_IDLE;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            aw_got_q  <= 1'b0;
            w_got_q   <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= OKAY;
        end else if (wstate_q == W_IDLE) begin
            aw_got_q  <= aw_got_d;
            w_got_q   <= w_got_d;
            awready_q <= !aw_got_d;
            wready_q  <= !w_got_d;
            if (aw_got_d && w_got_d) begin
                wstate_q <= W_RESP;
                bvalid_q <= 1'b1;
                bresp_q  <= (WR_ERR != 0) ? SLVERR : OKAY;
            end
        end else if (s_axi_bready) begin
            wstate_q  <= W_IDLE;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            aw_got_q  <= 1'b0;
            w_got_q   <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= OKAY;
        end
    end

    assign s_axi_arready = arready_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = rresp_q;
    assign rd_strobe     = rd_strobe_q;
    assign s_axi_awready = awready_q;
    assign s_axi_wready  = wready_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = bresp_q;
endmodule

// File: tb/tb_axil_read_regbank.sv
// tb_axil_read_regbank: directed checks of two bank instances sharing stimulus;
// u0 uses pair snapshots with OKAY writes, u1 reads live data and answers writes with SLVERR.
module tb_axil_read_regbank;
    logic         aclk, aresetn;
    logic [15:0]  awaddr, araddr;
    logic [2:0]   awprot, arprot;
    logic         awvalid, wvalid, bready, arvalid, rready;
    logic [31:0]  wdata;
    logic [3:0]   wstrb;
    logic [255:0] readdata;
    logic         awr [2], wr [2], bv [2], arr [2], rv [2];
    logic [1:0]   br [2], rr [2];
    logic [31:0]  rd [2];
    logic [7:0]   stb [2];
    int           total, bad;

    typedef struct {
        logic [15:0] addr;
        logic [31:0] e0;
        logic [31:0] e1;
        logic [1:0]  resp;
        logic [7:0]  strobe;
    } vec_t;
    vec_t vt [10];

    axil_read_regbank u0 (
        .aclk(aclk), .aresetn(aresetn),
        .s_axi_awaddr(awaddr), .s_axi_awprot(awprot), .s_axi_awvalid(awvalid), .s_axi_awready(awr[0]),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wr[0]),
        .s_axi_bresp(br[0]), .s_axi_bvalid(bv[0]), .s_axi_bready(bready),
        .s_axi_araddr(araddr), .s_axi_arprot(arprot), .s_axi_arvalid(arvalid), .s_axi_arready(arr[0]),
        .s_axi_rdata(rd[0]), .s_axi_rresp(rr[0]), .s_axi_rvalid(rv[0]), .s_axi_rready(rready),
        .readdata(readdata), .rd_strobe(stb[0])
    );

    axil_read_regbank #(.PAIR_SNAPSHOT(0), .WR_ERR(1)) u1 (
        .aclk(aclk), .aresetn(aresetn),
        .s_axi_awaddr(awaddr), .s_axi_awprot(awprot), .s_axi_awvalid(awvalid), .s_axi_awready(awr[1]),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wr[1]),
        .s_axi_bresp(br[1]), .s_axi_bvalid(bv[1]), .s_axi_bready(bready),
        .s_axi_araddr(araddr), .s_axi_arprot(arprot), .s_axi_arvalid(arvalid), .s_axi_arready(arr[1]),
        .s_axi_rdata(rd[1]), .s_axi_rresp(rr[1]), .s_axi_rvalid(rv[1]), .s_axi_rready(rready),
        .readdata(readdata), .rd_strobe(stb[1])
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_both(input string nm, input int sel, input logic [31:0] e0, input logic [31:0] e1);
        for (int u = 0; u < 2; u++) begin
            logic [31:0] a;
            case (sel)
                0: a = 32'(awr[u]);
                1: a = 32'(wr[u]);
                2: a = 32'(bv[u]);
                3: a = 32'(br[u]);
                4: a = 32'(arr[u]);
                5: a = 32'(rv[u]);
                6: a = rd[u];
                7: a = 32'(rr[u]);
                default: a = 32'(stb[u]);
            endcase
            chk($sformatf("%s.u%0d", nm, u), a, (u == 0) ? e0 : e1);
        end
    endtask

    task automatic setw(input int i, input logic [31:0] v);
        readdata[32*i +: 32] = v;
    endtask

    task automatic rd_chk(input string nm, input logic [15:0] a, input logic [31:0] e0, input logic [31:0] e1,
                          input logic [1:0] er, input logic [7:0] es);
        araddr  = a;
        arvalid = 1'b1;
        @(negedge aclk);
        arvalid = 1'b0;
        chk_both({nm, ".rvalid"}, 5, 1, 1);
        chk_both({nm, ".rdata"}, 6, e0, e1);
        chk_both({nm, ".rresp"}, 7, 32'(er), 32'(er));
        chk_both({nm, ".arready_busy"}, 4, 0, 0);
        chk_both({nm, ".strobe_early"}, 8, 0, 0);
        rready = 1'b1;
        @(negedge aclk);
        rready = 1'b0;
        chk_both({nm, ".rvalid_clr"}, 5, 0, 0);
        chk_both({nm, ".rdata_clr"}, 6, 0, 0);
        chk_both({nm, ".arready_back"}, 4, 1, 1);
        chk_both({nm, ".strobe"}, 8, 32'(es), 32'(es));
        @(negedge aclk);
        chk_both({nm, ".strobe_end"}, 8, 0, 0);
    endtask

    initial begin
        total = 0; bad = 0;
        aresetn = 1'b0;
        awaddr = 16'h0; araddr = 16'h0; awprot = 3'h0; arprot = 3'h0;
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
        wdata = 32'h0; wstrb = 4'hF;
        for (int i = 0; i < 8; i++) setw(i, 32'h11111111 * 32'(i + 1));
        vt[0] = '{16'h0000, 32'h11111111, 32'h11111111, 2'b00, 8'h01};
        vt[1] = '{16'h0004, 32'h22222222, 32'h22222222, 2'b00, 8'h02};
        vt[2] = '{16'h001F, 32'h00000000, 32'h88888888, 2'b00, 8'h80};
        vt[3] = '{16'h0018, 32'h77777777, 32'h77777777, 2'b00, 8'h40};
        vt[4] = '{16'h001C, 32'h88888888, 32'h88888888, 2'b00, 8'h80};
        vt[5] = '{16'h0020, 32'h00000000, 32'h00000000, 2'b10, 8'h00};
        vt[6] = '{16'h8000, 32'h00000000, 32'h00000000, 2'b10, 8'h00};
        vt[7] = '{16'h0008, 32'h33333333, 32'h33333333, 2'b00, 8'h04};
        vt[8] = '{16'h000E, 32'h44444444, 32'h44444444, 2'b00, 8'h08};
        vt[9] = '{16'hFFFF, 32'h00000000, 32'h00000000, 2'b10, 8'h00};

        repeat (3) @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        chk_both("rst.arready", 4, 1, 1);
        chk_both("rst.awready", 0, 1, 1);
        chk_both("rst.wready", 1, 1, 1);
        chk_both("rst.rvalid", 5, 0, 0);
        chk_both("rst.bvalid", 2, 0, 0);
        chk_both("rst.rdata", 6, 0, 0);
        chk_both("rst.rresp", 7, 0, 0);
        chk_both("rst.bresp", 3, 0, 0);
        chk_both("rst.strobe", 8, 0, 0);

        for (int i = 0; i < 10; i++)
            rd_chk($sformatf("vec%0d", i), vt[i].addr, vt[i].e0, vt[i].e1, vt[i].resp, vt[i].strobe);

        setw(1, 32'hAAAA0001);
        rd_chk("pair0", 16'h0, 32'h11111111, 32'h11111111, 2'b00, 8'h01);
        setw(1, 32'hBBBB0002);
        rd_chk("pair1", 16'h4, 32'hAAAA0001, 32'hBBBB0002, 2'b00, 8'h02);
        setw(1, 32'hCCCC0003);
        rd_chk("pair2", 16'h4, 32'hAAAA0001, 32'hCCCC0003, 2'b00, 8'h02);

        araddr = 16'h8; arvalid = 1'b1;
        @(negedge aclk);
        arvalid = 1'b0;
        setw(2, 32'hDEAD0000);
        for (int c = 0; c < 5; c++) begin
            chk_both($sformatf("bp%0d.rdata", c), 6, 32'h33333333, 32'h33333333);
            chk_both($sformatf("bp%0d.arready", c), 4, 0, 0);
            chk_both($sformatf("bp%0d.rvalid", c), 5, 1, 1);
            @(negedge aclk);
        end
        rready = 1'b1;
        @(negedge aclk);
        rready = 1'b0;
        chk_both("bp.arready", 4, 1, 1);
        chk_both("bp.rdata", 6, 0, 0);
        chk_both("bp.strobe", 8, 32'h04, 32'h04);

        awaddr = 16'h1234; wdata = 32'hCAFEF00D; awvalid = 1'b1;
        @(negedge aclk);
        awvalid = 1'b0;
        chk_both("wr.awready_lo", 0, 0, 0);
        chk_both("wr.wready_hi", 1, 1, 1);
        chk_both("wr.bvalid_aw", 2, 0, 0);
        repeat (2) @(negedge aclk);
        chk_both("wr.bvalid_wait", 2, 0, 0);
        wvalid = 1'b1;
        @(negedge aclk);
        wvalid = 1'b0;
        chk_both("wr.bvalid", 2, 1, 1);
        chk_both("wr.bresp", 3, 0, 2);
        chk_both("wr.wready_lo", 1, 0, 0);
        @(negedge aclk);
        chk_both("wr.bvalid_hold", 2, 1, 1);
        bready = 1'b1;
        @(negedge aclk);
        bready = 1'b0;
        chk_both("wr.bvalid_clr", 2, 0, 0);
        chk_both("wr.bresp_clr", 3, 0, 0);
        chk_both("wr.awready_back", 0, 1, 1);
        chk_both("wr.wready_back", 1, 1, 1);

        wvalid = 1'b1;
        @(negedge aclk);
        wvalid = 1'b0;
        chk_both("wfirst.wready", 1, 0, 0);
        chk_both("wfirst.awready", 0, 1, 1);
        chk_both("wfirst.bvalid", 2, 0, 0);
        awvalid = 1'b1;
        @(negedge aclk);
        awvalid = 1'b0;
        chk_both("wfirst.bvalid_set", 2, 1, 1);
        bready = 1'b1;
        @(negedge aclk);
        bready = 1'b0;
        chk_both("wfirst.bvalid_clr", 2, 0, 0);

        awvalid = 1'b1; wvalid = 1'b1; araddr = 16'h10; arvalid = 1'b1;
        @(negedge aclk);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        chk_both("conc.bvalid", 2, 1, 1);
        chk_both("conc.bresp", 3, 0, 2);
        chk_both("conc.rvalid", 5, 1, 1);
        chk_both("conc.rdata", 6, 32'h55555555, 32'h55555555);
        bready = 1'b1; rready = 1'b1;
        @(negedge aclk);
        bready = 1'b0; rready = 1'b0;
        chk_both("conc.bvalid_clr", 2, 0, 0);
        chk_both("conc.rvalid_clr", 5, 0, 0);
        chk_both("conc.strobe", 8, 32'h10, 32'h10);
        chk_both("conc.awready", 0, 1, 1);
        chk_both("conc.arready", 4, 1, 1);

        araddr = 16'h8; arvalid = 1'b1;
        @(negedge aclk);
        arvalid = 1'b0;
        chk_both("rstmid.rvalid_pre", 5, 1, 1);
        aresetn = 1'b0;
        @(negedge aclk);
        chk_both("rstmid.rvalid", 5, 0, 0);
        chk_both("rstmid.arready", 4, 1, 1);
        chk_both("rstmid.rdata", 6, 0, 0);
        aresetn = 1'b1;
        @(negedge aclk);
        chk_both("rstmid.strobe", 8, 0, 0);
        rd_chk("rstmid.shadow", 16'hC, 32'h00000000, 32'h44444444, 2'b00, 8'h08);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/axil_read_regbank.md
# axil_read_regbank

Parametrised AXI4-Lite read-register bank of NUM_WORDS 32-bit status words, the generalised successor to the fixed two-word read register. It sits on the processor AXI4-Lite interconnect and exposes FPGA status and counter values to software. Even/odd word pairs can be read coherently through a hi-word shadow snapshot. The block implements a full write channel that drains and acknowledges writes, and it produces per-word read strobes for clear-on-read sources.

## Interface
- AXI_DATA_WIDTH, 32: bus data width; only 32 is supported.
- AXI_ADDR_WIDTH, 16: byte address width.
- NUM_WORDS, 8: number of readable words; a power of 2, from 2 to 256. IDXW = clog2(NUM_WORDS).
- PAIR_SNAPSHOT, 1: 1 = reading word 2k snapshots word 2k+1 into a shadow register; 0 = all reads return live data.
- WR_ERR, 0: 0 = writes get OKAY (2'b00); 1 = writes get SLVERR (2'b10). Write data is always discarded.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  reset; synchronous, active-low.
- s_axi_aw*, s_axi_w*, s_axi_b*, s_axi_ar*, s_axi_r*: standard AXI4-Lite slave channels. Widths follow AXI_ADDR_WIDTH and AXI_DATA_WIDTH; resp fields are 2 bits.
- readdata  in  NUM_WORDS*32  flattened status words; word i = readdata[32i+31:32i].
- rd_strobe  out  NUM_WORDS  one-cycle pulse on bit i when a read of word i completes its R handshake.

## Operation
- Addressing:
  - Word index = araddr[IDXW+1:2]; araddr[1:0] is ignored.
  - The address is in range when araddr[AXI_ADDR_WIDTH-1:IDXW+2] == 0.
- Read FSM states: R_IDLE (arready=1), R_DATA (rvalid=1).
  - R_IDLE -> R_DATA on arvalid&arready. At that same edge:
    - In range: rdata <= selected word, rresp <= OKAY.
    - Out of range: rdata <= 0, rresp <= SLVERR, and rd_strobe does not fire.
  - R_DATA -> R_IDLE on rvalid&rready. On that edge rdata and rresp clear to 0, and rd_strobe[idx] pulses in the following cycle.
- Snapshot (PAIR_SNAPSHOT=1):
  - An in-range AR handshake for even index 2k also loads shadow[k] <= readdata word 2k+1.
  - A read of index 2k+1 returns shadow[k], not live data.
  - There are NUM_WORDS/2 shadow registers, each resetting to 0.
  - An odd read does not modify any shadow.
- Write channel, independent of the read channel. States: W_IDLE, W_RESP.
  - In W_IDLE, awready and wready are both high.
  - An AW handshake sets aw_got and drops awready. A W handshake sets w_got and drops wready. They may occur in either order or in the same cycle.
  - When aw_got and w_got are both set: go to W_RESP, bvalid=1, bresp = WR_ERR ? SLVERR : OKAY.
  - On bvalid&bready: clear the flags, bresp <= 0, return to W_IDLE.
- Reads and writes may be in progress simultaneously without interaction.

## Timing
- Reset values:
  - arready=1, awready=1, wready=1.
  - rvalid=0, bvalid=0, rdata=0, rresp=0, bresp=0, rd_strobe=0.
  - All shadows 0, both FSMs idle.
- Read latency: AR handshake at edge T; rvalid=1 with data from cycle T; the data is sampled at the handshake edge.
- rdata and rresp stay stable while rvalid=1 and rready=0.
- arready is low from T+1 until the R handshake and returns high the cycle after it. Back-to-back reads therefore take a minimum of 2 cycles each.
- Write response: bvalid is asserted the cycle after the later of the AW and W handshakes. awready/wready return high the cycle after the B handshake.
- rd_strobe is registered: it is high for exactly one cycle, one cycle after the R handshake.
- Reset asserted mid-transaction: all state and outputs return to their reset values on that edge, and the in-flight transaction is abandoned.

## Test plan
- Reset, then read address 0x0 with readdata word0=0x11111111 -> rvalid one cycle after handshake, rdata=0x11111111, rresp=0, rd_strobe=0x01 pulse of one cycle.
- Coherent pair: read 0x0 while word1=0xAAAA0001, then set word1=0xBBBB0002, then read 0x4 -> rdata=0xAAAA0001. Repeat with PAIR_SNAPSHOT=0 -> rdata=0xBBBB0002.
- Backpressure: hold rready=0 for 5 cycles after rvalid -> rdata stable, arready=0 throughout; rready=1 -> arready=1 on the next cycle, rdata=0.
- Out of range with NUM_WORDS=8: read 0x20 -> rresp=2'b10, rdata=0, rd_strobe stays 0.
- Writes: AW at cycle 0, W at cycle 3 -> bvalid at cycle 4; then AW and W in the same cycle -> bvalid the next cycle; bresp=0, or 2'b10 with WR_ERR=1. A read issued concurrently completes normally.
- Reset mid-read (aresetn low while rvalid=1) -> rvalid=0, arready=1, shadows=0 after the edge.
